fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 384, meaning the number of valid words per frame bank.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, meaning the maximum consecutive cycles a pending write may lose arbitration.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 disp_req  in  1  display requests one word read this cycle.
REQ-006 disp_addr  in  9  word address within the front bank.
REQ-007 disp_ack  out  1  display read granted this cycle.
REQ-008 disp_valid  out  1  disp_data valid; asserts one cycle after disp_ack.
REQ-009 disp_data  out  32  read word: 8 pixels, 4 bits each, pixel 0 in [3:0].
REQ-010 wr_valid  in  1  writer offers a word.
REQ-011 wr_ready  out  1  write accepted this cycle; transfer occurs when wr_valid and wr_ready are both high.
REQ-012 wr_addr  in  9  word address within the back bank.
REQ-013 wr_data  in  32  write word.
REQ-014 swap_req  in  1  single-cycle pulse requesting a front/back bank exchange.
REQ-015 frame_start  in  1  single-cycle pulse at the display frame boundary.
REQ-016 front_bank  out  1  bank the display reads; the writer targets ~front_bank.
REQ-017 swap_pending  out  1  a swap is waiting for frame_start.
REQ-018 wr_err  out  1  one-cycle pulse: an out-of-range write was dropped.
REQ-019 sram_addr  out  10  {bank, word}; 0 when idle.
REQ-020 sram_din  out  32  write data; 0 when not writing.
REQ-021 sram_we  out  1  SRAM write strobe.
REQ-022 sram_rd  out  1  SRAM read strobe.
REQ-023 sram_dout  in  32  SRAM read data, valid the cycle after sram_rd.

Function
REQ-024 SHALL grant at most one requester per cycle; disp_ack, wr_ready, sram_rd and sram_we are combinational from the current inputs and state.
REQ-025 SHALL grant the display by default: disp_req=1 gives disp_ack=1, sram_rd=1 and sram_addr={front_bank, disp_addr}.
REQ-026 SHALL grant the writer when disp_req=0, or when the starve counter equals STARVE_LIMIT: wr_ready=1, sram_we=1, sram_addr={~front_bank, wr_addr}, sram_din=wr_data.
REQ-027 SHALL increment the starve counter each cycle that wr_valid=1 and the write is not accepted, and clear it on write acceptance or when wr_valid=0; the counter saturates at STARVE_LIMIT.
REQ-028 SHALL drive disp_valid=1 and disp_data=sram_dout in the cycle after a disp_ack; otherwise disp_valid=0 and disp_data=0.
REQ-029 SHALL, for disp_addr >= FRAME_WORDS, still assert disp_ack but keep sram_rd=0, and return disp_data=0 with disp_valid=1 one cycle later.
REQ-030 SHALL, for wr_addr >= FRAME_WORDS, still complete the handshake (wr_ready=1) but keep sram_we=0, and pulse wr_err in the next cycle.
REQ-031 SHALL implement the swap FSM as IDLE -> PENDING on swap_req, and PENDING -> IDLE on frame_start while toggling front_bank; swap_req while PENDING is ignored.
REQ-032 SHALL treat swap_req and frame_start in the same cycle in IDLE as an immediate swap: front_bank toggles at that edge and the FSM stays IDLE.
REQ-033 SHALL ignore frame_start in IDLE; swap_pending=1 exactly when the FSM is in PENDING.
REQ-034 SHALL sample bank selection at grant time, so a grant in the cycle of the swap edge uses the pre-swap front_bank.

Reset
REQ-035 SHALL, while rst=1, drive disp_ack, wr_ready, sram_rd, sram_we, sram_addr and sram_din to 0.
REQ-036 SHALL, on reset, set front_bank=0, swap FSM=IDLE, starve counter=0, disp_valid=0, disp_data=0 and wr_err=0.
REQ-037 SHALL discard any read outstanding when rst asserts (no disp_valid after reset) and drop a pending swap.

Structure
REQ-038 SHALL take FRAME_WORDS, ADDR_W=9, DATA_W=32 and the swap-state enum {IDLE, PENDING} from shared package fb_pkg.
REQ-039 SHALL place the swap FSM in sub-module fb_swap_ctrl (ports clk, rst, swap_req, frame_start, front_bank, swap_pending); arbitration remains in fb_arbiter.

Verification
REQ-040 Display-only read: disp_req=1, disp_addr=5, front_bank=0 -> sram_rd=1, sram_addr=10'd5; next cycle disp_valid=1, disp_data=sram_dout.
REQ-041 Starvation: disp_req held high, wr_valid=1 -> wr_ready=0 for 8 cycles, then wr_ready=1 with disp_ack=0 on cycle 9, and sram_addr=512+wr_addr.
REQ-042 Swap: swap_req pulse, then frame_start after 20 cycles -> swap_pending=1 for 20 cycles, then front_bank=1 and writes target addresses 0..383.
REQ-043 Simultaneous swap_req and frame_start in IDLE -> front_bank toggles at that edge, swap_pending never asserts.
REQ-044 Out of range: wr_addr=400 -> handshake completes, sram_we=0, wr_err pulses once; disp_addr=384 -> disp_valid with data 0.
REQ-045 Reset mid-read: rst asserted the cycle after disp_ack -> disp_valid=0, front_bank=0, all SRAM strobes 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the double-buffered frame store: sizes, widths, swap states.
// No logic; the one helper function is purely combinational.
// No flow control.
package fb_pkg;

  localparam int FRAME_WORDS = 384;
  localparam int ADDR_W      = 9;
  localparam int DATA_W      = 32;
  localparam int SRAM_AW     = ADDR_W + 1;  // {bank, word}

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_e;

  // True when a word address lies inside the populated part of a bank.
  function automatic logic in_frame(input logic [ADDR_W-1:0] addr, input int words);
    return int'(addr) < words;
  endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// Bundle of the display, writer, bank-control and SRAM signals of the frame-buffer arbiter.
// Wires only; no latency.
// Writer uses valid/ready; display uses req/ack; SRAM side has no flow control.
// Ports: slave = arbiter view, master = client/SRAM view.
interface fb_arbiter_if;
  import fb_pkg::*;

  // display read port
  logic                 disp_req;
  logic [ADDR_W-1:0]    disp_addr;
  logic                 disp_ack;
  logic                 disp_valid;
  logic [DATA_W-1:0]    disp_data;
  // writer port
  logic                 wr_valid;
  logic                 wr_ready;
  logic [ADDR_W-1:0]    wr_addr;
  logic [DATA_W-1:0]    wr_data;
  logic                 wr_err;
  // bank control
  logic                 swap_req;
  logic                 frame_start;
  logic                 front_bank;
  logic                 swap_pending;
  // SRAM
  logic [SRAM_AW-1:0]   sram_addr;
  logic [DATA_W-1:0]    sram_din;
  logic                 sram_we;
  logic                 sram_rd;
  logic [DATA_W-1:0]    sram_dout;

  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data,
           swap_req, frame_start, sram_dout,
    output disp_ack, disp_valid, disp_data, wr_ready, wr_err,
           front_bank, swap_pending, sram_addr, sram_din, sram_we, sram_rd
  );

  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data,
           swap_req, frame_start, sram_dout,
    input  disp_ack, disp_valid, disp_data, wr_ready, wr_err,
           front_bank, swap_pending, sram_addr, sram_din, sram_we, sram_rd
  );

endinterface

// File: rtl/fb_swap_ctrl.sv
// Front/back bank swap controller: a requested swap waits for the next frame boundary.
// front_bank changes at the clock edge that sees frame_start (or swap_req+frame_start in IDLE).
// No backpressure; swap_req arriving while a swap is already pending is dropped.
// Ports: clk, rst (sync, active high), swap_req, frame_start -> front_bank, swap_pending.
module fb_swap_ctrl
  import fb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic swap_req,
  input  logic frame_start,
  output logic front_bank,
  output logic swap_pending
);

  swap_state_e state_q, state_d;
  logic        front_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      front_bank <= 1'b0;
    end else begin
      state_q    <= state_d;
      front_bank <= front_d;
    end
  end

  always_comb begin
    state_d = state_q;
    front_d = front_bank;
    case (state_q)
      IDLE: begin
        if (swap_req && frame_start) begin
          // Request lands exactly on the boundary: swap now, nothing left to wait for.
          front_d = ~front_bank;
        end else if (swap_req) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (frame_start) begin
          front_d = ~front_bank;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign swap_pending = (state_q == PENDING);

endmodule

// File: rtl/fb_arbiter.sv
// Single-port SRAM arbiter for a double-buffered frame store: display reads front, writer fills back.
// Grants are combinational; display data returns one cycle after disp_ack.
// Display wins by default; a write that has lost STARVE_LIMIT cycles in a row pre-empts the display.
// Ports: clk, rst (sync, active high), bus (fb_arbiter_if.slave).
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int FRAME_WORDS  = fb_pkg::FRAME_WORDS,
  parameter int STARVE_LIMIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  fb_arbiter_if.slave  bus
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic             front_bank;
  logic [CNT_W-1:0] starve_q;
  logic             wr_prio;
  logic             rd_ok, wr_ok, wr_fire;
  logic             disp_ack, wr_ready, sram_rd, sram_we;
  logic             rd_pend_q;  // a display read was acked last cycle
  logic             rd_hit_q;   // ... and it actually touched the SRAM
  logic             err_q;

  fb_swap_ctrl u_swap (
    .clk          (clk),
    .rst          (rst),
    .swap_req     (bus.swap_req),
    .frame_start  (bus.frame_start),
    .front_bank   (front_bank),
    .swap_pending (bus.swap_pending)
  );

  assign bus.front_bank = front_bank;

  assign rd_ok   = in_frame(bus.disp_addr, FRAME_WORDS);
  assign wr_ok   = in_frame(bus.wr_addr, FRAME_WORDS);
  assign wr_prio = bus.wr_valid && (starve_q == STARVE_MAX);

  // Out-of-range accesses still complete their handshake so neither side stalls,
  // they just never reach the SRAM.
  always_comb begin
    disp_ack      = 1'b0;
    wr_ready      = 1'b0;
    sram_rd       = 1'b0;
    sram_we       = 1'b0;
    bus.sram_addr = '0;
    bus.sram_din  = '0;
    if (!rst) begin
      disp_ack = bus.disp_req && !wr_prio;
      wr_ready = !disp_ack;
      sram_rd  = disp_ack && rd_ok;
      sram_we  = wr_ready && bus.wr_valid && wr_ok;
      if (sram_rd) begin
        bus.sram_addr = {front_bank, bus.disp_addr};
      end else if (sram_we) begin
        bus.sram_addr = {~front_bank, bus.wr_addr};
        bus.sram_din  = bus.wr_data;
      end
    end
  end

  assign wr_fire = bus.wr_valid && wr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q  <= '0;
      rd_pend_q <= 1'b0;
      rd_hit_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rd_pend_q <= disp_ack;
      rd_hit_q  <= sram_rd;
      err_q     <= wr_fire && !wr_ok;
      if (bus.wr_valid && !wr_ready) begin
        if (starve_q != STARVE_MAX) starve_q <= starve_q + 1'b1;
      end else begin
        starve_q <= '0;
      end
    end
  end

  assign bus.disp_ack   = disp_ack;
  assign bus.wr_ready   = wr_ready;
  assign bus.sram_rd    = sram_rd;
  assign bus.sram_we    = sram_we;
  // Gated by rst so a read in flight when reset hits never reports.
  assign bus.disp_valid = rd_pend_q && !rst;
  assign bus.disp_data  = (rd_pend_q && !rst && rd_hit_q) ? bus.sram_dout : '0;
  assign bus.wr_err     = err_q && !rst;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed scenarios plus randomized traffic against a
// behavioural model of the frame store (bank contents, starvation count, swap state).
module tb_fb_arbiter;

  localparam int FW    = 384;
  localparam int SLIM  = 8;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  fb_arbiter_if ifc ();

  fb_arbiter #(.FRAME_WORDS(FW), .STARVE_LIMIT(SLIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM driven only by the DUT's strobes.
  logic [31:0] sram_mem [0:1023];
  always @(posedge clk) begin
    if (ifc.sram_we) sram_mem[ifc.sram_addr] <= ifc.sram_din;
    if (ifc.sram_rd) ifc.sram_dout <= sram_mem[ifc.sram_addr];
    else             ifc.sram_dout <= $urandom;
  end

  // Reference model state.
  logic [31:0] ref_mem [0:1023];
  int m_front, m_starve, m_rdidx;
  bit m_pend, m_rdv, m_rdhit, m_err;

  // Observed outputs, captured mid-cycle by step().
  logic obs_ack, obs_wrdy, obs_rd, obs_we, obs_dv, obs_err, obs_front, obs_pend;
  logic [9:0]  obs_addr;
  logic [31:0] obs_din, obs_dd;

  task automatic idle();
    ifc.disp_req = 0; ifc.disp_addr = '0; ifc.wr_valid = 0; ifc.wr_addr = '0;
    ifc.wr_data = '0; ifc.swap_req = 0; ifc.frame_start = 0;
  endtask

  task automatic model_reset();
    m_front = 0; m_starve = 0; m_rdidx = 0;
    m_pend = 0; m_rdv = 0; m_rdhit = 0; m_err = 0;
  endtask

  // One clock cycle: predict from the model, compare mid-cycle, then advance the model.
  task automatic step();
    bit rin, win, wprio, e_ack, e_wrdy, e_rd, e_we, e_dv, e_err;
    int a;
    logic [9:0]  e_addr;
    logic [31:0] e_din, e_dd;
    rin   = int'(ifc.disp_addr) < FW;
    win   = int'(ifc.wr_addr) < FW;
    wprio = (m_starve == SLIM) && ifc.wr_valid;
    e_ack = !rst && ifc.disp_req && !wprio;
    e_wrdy = !rst && !e_ack;
    e_rd  = e_ack && rin;
    e_we  = e_wrdy && ifc.wr_valid && win;
    a = 0;
    if (e_rd) a = m_front * 512 + int'(ifc.disp_addr);
    else if (e_we) a = (1 - m_front) * 512 + int'(ifc.wr_addr);
    e_addr = 10'(a);
    e_din  = e_we ? ifc.wr_data : 32'h0;
    e_dv   = m_rdv && !rst;
    e_dd   = (e_dv && m_rdhit) ? ref_mem[m_rdidx] : 32'h0;
    e_err  = m_err && !rst;

    @(negedge clk);
    obs_ack = ifc.disp_ack; obs_wrdy = ifc.wr_ready; obs_rd = ifc.sram_rd; obs_we = ifc.sram_we;
    obs_addr = ifc.sram_addr; obs_din = ifc.sram_din; obs_dv = ifc.disp_valid;
    obs_dd = ifc.disp_data; obs_err = ifc.wr_err; obs_front = ifc.front_bank;
    obs_pend = ifc.swap_pending;
    total++; if (obs_ack !== e_ack) begin bad++; $display("FAIL disp_ack cyc=%0d got=%b want=%b", cyc, obs_ack, e_ack); end
    total++; if (obs_wrdy !== e_wrdy) begin bad++; $display("FAIL wr_ready cyc=%0d got=%b want=%b", cyc, obs_wrdy, e_wrdy); end
    total++; if (obs_rd !== e_rd) begin bad++; $display("FAIL sram_rd cyc=%0d got=%b want=%b", cyc, obs_rd, e_rd); end
    total++; if (obs_we !== e_we) begin bad++; $display("FAIL sram_we cyc=%0d got=%b want=%b", cyc, obs_we, e_we); end
    total++; if (obs_addr !== e_addr) begin bad++; $display("FAIL sram_addr cyc=%0d got=%h want=%h", cyc, obs_addr, e_addr); end
    total++; if (obs_din !== e_din) begin bad++; $display("FAIL sram_din cyc=%0d got=%h want=%h", cyc, obs_din, e_din); end
    total++; if (obs_dv !== e_dv) begin bad++; $display("FAIL disp_valid cyc=%0d got=%b want=%b", cyc, obs_dv, e_dv); end
    total++; if (obs_dd !== e_dd) begin bad++; $display("FAIL disp_data cyc=%0d got=%h want=%h", cyc, obs_dd, e_dd); end
    total++; if (obs_err !== e_err) begin bad++; $display("FAIL wr_err cyc=%0d got=%b want=%b", cyc, obs_err, e_err); end
    total++; if (obs_front !== 1'(m_front)) begin bad++; $display("FAIL front_bank cyc=%0d got=%b want=%0d", cyc, obs_front, m_front); end
    total++; if (obs_pend !== m_pend) begin bad++; $display("FAIL swap_pending cyc=%0d got=%b want=%b", cyc, obs_pend, m_pend); end

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (e_we) ref_mem[a] = ifc.wr_data;
      m_rdv   = e_ack;
      m_rdhit = e_rd;
      m_rdidx = m_front * 512 + int'(ifc.disp_addr);
      m_err   = e_wrdy && ifc.wr_valid && !win;
      if (ifc.wr_valid && !e_wrdy) m_starve = (m_starve < SLIM) ? m_starve + 1 : SLIM;
      else m_starve = 0;
      if (m_pend) begin
        if (ifc.frame_start) begin m_front = 1 - m_front; m_pend = 0; end
      end else if (ifc.swap_req) begin
        if (ifc.frame_start) m_front = 1 - m_front;
        else m_pend = 1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; ifc.disp_req = 1; ifc.wr_valid = 1; ifc.swap_req = 1; ifc.frame_start = 0;
    step();
    total++; if (obs_ack !== 1'b0 || obs_wrdy !== 1'b0) begin bad++; $display("FAIL reset_grants got=%b%b want=00", obs_ack, obs_wrdy); end
    total++; if (obs_addr !== 10'd0 || obs_din !== 32'd0) begin bad++; $display("FAIL reset_sram got=%h/%h want=0/0", obs_addr, obs_din); end
    total++; if (obs_dv !== 1'b0 || obs_err !== 1'b0) begin bad++; $display("FAIL reset_dv_err got=%b%b want=00", obs_dv, obs_err); end
    rst = 0; idle();
    step();
    total++; if (obs_front !== 1'b0 || obs_pend !== 1'b0) begin bad++; $display("FAIL reset_bank got=%b%b want=00", obs_front, obs_pend); end
  endtask

  task automatic test_display_read();
    idle(); ifc.wr_valid = 1; ifc.wr_addr = 9'd5; ifc.wr_data = 32'h1111_5555;
    step();
    total++; if (obs_we !== 1'b1 || obs_addr !== 10'd517) begin bad++; $display("FAIL first_write got=%b/%0d want=1/517", obs_we, obs_addr); end
    idle(); ifc.swap_req = 1; ifc.frame_start = 1; step();
    idle(); ifc.wr_valid = 1; ifc.wr_addr = 9'd5; ifc.wr_data = 32'h7654_3210;
    step();
    total++; if (obs_addr !== 10'd5) begin bad++; $display("FAIL bank0_write addr got=%0d want=5", obs_addr); end
    idle(); ifc.swap_req = 1; ifc.frame_start = 1; step();
    idle(); ifc.disp_req = 1; ifc.disp_addr = 9'd5;
    step();
    total++; if (obs_rd !== 1'b1 || obs_addr !== 10'd5) begin bad++; $display("FAIL disp_read got=%b/%0d want=1/5", obs_rd, obs_addr); end
    idle(); step();
    total++; if (obs_dv !== 1'b1 || obs_dd !== 32'h7654_3210) begin bad++; $display("FAIL disp_return got=%b/%h want=1/76543210", obs_dv, obs_dd); end
  endtask

  task automatic test_starvation();
    idle(); step();
    ifc.disp_req = 1; ifc.disp_addr = 9'd40; ifc.wr_valid = 1; ifc.wr_addr = 9'd17; ifc.wr_data = 32'hABCD_0017;
    for (int i = 0; i < SLIM; i++) begin
      step();
      total++; if (obs_wrdy !== 1'b0 || obs_ack !== 1'b1) begin bad++; $display("FAIL starve_lose i=%0d got rdy=%b ack=%b want 0/1", i, obs_wrdy, obs_ack); end
    end
    step();
    total++; if (obs_wrdy !== 1'b1 || obs_ack !== 1'b0) begin bad++; $display("FAIL starve_win got rdy=%b ack=%b want 1/0", obs_wrdy, obs_ack); end
    total++; if (obs_addr !== 10'd529) begin bad++; $display("FAIL starve_addr got=%0d want=529", obs_addr); end
    step();
    total++; if (obs_wrdy !== 1'b0 || obs_ack !== 1'b1) begin bad++; $display("FAIL starve_cleared got rdy=%b ack=%b want 0/1", obs_wrdy, obs_ack); end
    idle(); step();
  endtask

  task automatic test_swap();
    idle(); ifc.swap_req = 1; step();
    for (int i = 0; i < 20; i++) begin
      idle(); ifc.swap_req = (i == 5); ifc.frame_start = (i == 19);
      step();
      total++; if (obs_pend !== 1'b1 || obs_front !== 1'b0) begin bad++; $display("FAIL swap_wait i=%0d got pend=%b front=%b want 1/0", i, obs_pend, obs_front); end
    end
    idle(); step();
    total++; if (obs_front !== 1'b1 || obs_pend !== 1'b0) begin bad++; $display("FAIL swap_done got front=%b pend=%b want 1/0", obs_front, obs_pend); end
    for (int a = 0; a < FW; a++) begin
      idle(); ifc.wr_valid = 1; ifc.wr_addr = 9'(a); ifc.wr_data = $urandom;
      step();
      total++; if (obs_we !== 1'b1 || obs_addr !== 10'(a)) begin bad++; $display("FAIL swap_fill a=%0d got we=%b addr=%0d", a, obs_we, obs_addr); end
    end
  endtask

  task automatic test_simul_swap();
    idle(); ifc.swap_req = 1; ifc.frame_start = 1;
    step();
    total++; if (obs_front !== 1'b1 || obs_pend !== 1'b0) begin bad++; $display("FAIL simul_pre got front=%b pend=%b want 1/0", obs_front, obs_pend); end
    idle(); step();
    total++; if (obs_front !== 1'b0 || obs_pend !== 1'b0) begin bad++; $display("FAIL simul_post got front=%b pend=%b want 0/0", obs_front, obs_pend); end
    ifc.frame_start = 1; step();
    idle(); step();
    total++; if (obs_front !== 1'b0) begin bad++; $display("FAIL idle_frame_start got front=%b want 0", obs_front); end
  endtask

  task automatic test_out_of_range();
    idle(); ifc.wr_valid = 1; ifc.wr_addr = 9'd400; ifc.wr_data = 32'hDEAD_BEEF;
    step();
    total++; if (obs_wrdy !== 1'b1 || obs_we !== 1'b0) begin bad++; $display("FAIL oor_write got rdy=%b we=%b want 1/0", obs_wrdy, obs_we); end
    idle(); step();
    total++; if (obs_err !== 1'b1) begin bad++; $display("FAIL oor_err_pulse got=%b want=1", obs_err); end
    step();
    total++; if (obs_err !== 1'b0) begin bad++; $display("FAIL oor_err_once got=%b want=0", obs_err); end
    ifc.disp_req = 1; ifc.disp_addr = 9'd384;
    step();
    total++; if (obs_ack !== 1'b1 || obs_rd !== 1'b0) begin bad++; $display("FAIL oor_read got ack=%b rd=%b want 1/0", obs_ack, obs_rd); end
    idle(); step();
    total++; if (obs_dv !== 1'b1 || obs_dd !== 32'h0) begin bad++; $display("FAIL oor_return got=%b/%h want=1/0", obs_dv, obs_dd); end
  endtask

  task automatic test_reset_mid_read();
    idle(); ifc.swap_req = 1; ifc.frame_start = 1; step();   // front -> 1
    idle(); ifc.swap_req = 1; step();                        // swap now pending
    idle(); ifc.disp_req = 1; ifc.disp_addr = 9'd3;
    step();
    total++; if (obs_ack !== 1'b1) begin bad++; $display("FAIL mid_read_ack got=%b want=1", obs_ack); end
    rst = 1; ifc.wr_valid = 1; ifc.wr_addr = 9'd9;
    step();
    total++; if (obs_dv !== 1'b0 || obs_rd !== 1'b0 || obs_we !== 1'b0) begin bad++; $display("FAIL mid_read_rst got dv=%b rd=%b we=%b want 000", obs_dv, obs_rd, obs_we); end
    rst = 0; idle(); step();
    total++; if (obs_dv !== 1'b0 || obs_front !== 1'b0 || obs_pend !== 1'b0) begin bad++; $display("FAIL after_rst got dv=%b front=%b pend=%b want 000", obs_dv, obs_front, obs_pend); end
    ifc.frame_start = 1; step();
    idle(); step();
    total++; if (obs_front !== 1'b0) begin bad++; $display("FAIL dropped_swap got front=%b want 0", obs_front); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      ifc.disp_req    = ($urandom_range(0, 9) < 7);
      ifc.disp_addr   = 9'($urandom_range(0, 420));
      ifc.wr_valid    = ($urandom_range(0, 9) < 6);
      ifc.wr_addr     = 9'($urandom_range(0, 420));
      ifc.wr_data     = $urandom;
      ifc.swap_req    = ($urandom_range(0, 19) == 0);
      ifc.frame_start = ($urandom_range(0, 19) == 0);
      step();
    end
    rst = 0; idle(); step(); step();
  endtask

  initial begin
    rst = 1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_display_read();
    test_starvation();
    test_swap();
    test_simul_swap();
    test_out_of_range();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
